// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential signed multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam int unsigned ITER = 32;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring shift-subtract divide.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic        op,
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    output logic [63:0] acc_next
);

    logic [32:0] sum;
    logic [32:0] partial;
    logic [31:0] diff;

    always_comb begin
        sum      = '0;
        partial  = '0;
        diff     = '0;
        acc_next = acc;
        if (op == OP_MUL) begin
            // acc = {partial product, remaining multiplier bits}; carry re-enters at bit 63
            sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
            acc_next = {sum, acc[31:1]};
        end else begin
            // acc = {remainder, dividend bits shifting out / quotient bits shifting in}
            partial = {acc[63:32], acc[31]};
            diff    = partial[31:0] - operand;
            if (partial >= {1'b0, operand}) begin
                acc_next = {diff, acc[30:0], 1'b1};
            end else begin
                acc_next = {partial[31:0], acc[30:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential 32-bit signed multiply / divide: magnitude iteration in CALC, sign fix in FIX.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic        DivZero,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic [4:0]  Count
);

    state_t      state_q, state_d;
    logic        op_q, op_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic [31:0] operand_q, operand_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        dz_q, dz_d;

    logic [63:0] acc_step;
    logic [63:0] product;
    logic [31:0] quotient;
    logic [31:0] remainder;

    muldiv_step u_step (
        .op       (op_q),
        .acc      (acc_q),
        .operand  (operand_q),
        .acc_next (acc_step)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        operand_d = operand_q;
        acc_d     = acc_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = dz_q;
        product   = (sign_a_q ^ sign_b_q) ? (~acc_q + 64'd1) : acc_q;
        quotient  = (sign_a_q ^ sign_b_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        remainder = sign_a_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    op_d     = Op;
                    sign_a_d = A[31];
                    sign_b_d = B[31];
                    count_d  = '0;
                    if (Op == OP_DIV && B == '0) begin
                        dz_d    = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        dz_d    = 1'b0;
                        state_d = ST_CALC;
                        if (Op == OP_MUL) begin
                            operand_d = abs32(A);
                            acc_d     = {32'd0, abs32(B)};
                        end else begin
                            operand_d = abs32(B);
                            acc_d     = {32'd0, abs32(A)};
                        end
                    end
                end
            end
            ST_CALC: begin
                acc_d = acc_step;
                if (count_q == 5'(ITER - 1)) begin
                    count_d = '0;
                    state_d = ST_FIX;
                end else begin
                    count_d = count_q + 5'd1;
                end
            end
            ST_FIX: begin
                if (op_q == OP_MUL) begin
                    hi_d = product[63:32];
                    lo_d = product[31:0];
                end else begin
                    hi_d = remainder;
                    lo_d = quotient;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                dz_d    = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MUL;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            operand_q <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dz_q      <= dz_d;
        end
    end

    assign Busy    = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign Done    = (state_q == ST_DONE);
    assign DivZero = dz_q && (state_q == ST_DONE);
    assign Hi      = hi_q;
    assign Lo      = lo_q;
    assign Count   = count_q;

endmodule
